// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell plus a carry flop, LSB first.
// A start accepted in IDLE or DONE loads the operands; WIDTH RUN cycles later
// the result is registered into sum/cout together with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_ps;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_maj;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_ps_next;

  // Full-adder cell over the current LSBs and the stored carry.
  assign w_s       = r_sa[0] ^ r_sb[0] ^ r_carry;
  assign w_maj     = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);
  assign w_ps_next = {w_s, r_ps[WIDTH-1:1]};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Control FSM: IDLE -> RUN (WIDTH cycles) -> DONE (one cycle) -> IDLE or RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_cnt   <= '0;
          r_state <= w_accept ? S_RUN : S_IDLE;
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: operand shifters, carry, partial sum; result registers load only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_ps    <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_sa    <= a;
      r_sb    <= b;
      r_ps    <= '0;
      r_carry <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_ps    <= w_ps_next;
      r_carry <= w_maj;
      if (w_last) begin
        r_sum  <= w_ps_next;
        r_cout <= w_maj;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=4): table vectors, exhaustive sweep and
// hand-written corner sequences, with results checked through a scoreboard queue.
module tb_serial_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  logic [W:0] sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic       prev_done = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected {cout,sum}; done must never last two cycles.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        logic [W:0] e;
        e = sb_q.pop_front();
        chk("result", int'({cout, sum}), int'(e));
      end
      chk("done_width", int'(prev_done), 0);
    end
    prev_done <= done;
  end

  // Counts negedges until done is seen, bounded.
  task automatic wait_done(inout int n);
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  // Launch one addition from a negedge, expect busy for W cycles then done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W:0] exp);
    int n;
    int nb;
    start = 1'b1; a = ta; b = tb_;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    n = 1; nb = 0;
    while (!done && n < 30) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    chk("latency", n, W + 1);
    chk("busy_cycles", nb, W);
  endtask

  initial begin
    vec_t tbl[6];
    int   n;
    int   cnt;
    tbl[0] = '{va: 4'd3,  vb: 4'd5,  es: 4'd8,  ec: 1'b0};
    tbl[1] = '{va: 4'd15, vb: 4'd1,  es: 4'd0,  ec: 1'b1};
    tbl[2] = '{va: 4'd15, vb: 4'd15, es: 4'd14, ec: 1'b1};
    tbl[3] = '{va: 4'd0,  vb: 4'd0,  es: 4'd0,  ec: 1'b0};
    tbl[4] = '{va: 4'd9,  vb: 4'd6,  es: 4'd15, ec: 1'b0};
    tbl[5] = '{va: 4'd8,  vb: 4'd8,  es: 4'd0,  ec: 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outs", int'({busy, done, sum, cout}), 0);

    // Table vectors (back-to-back when one ends on a done cycle).
    for (int i = 0; i < 6; i++) run_op(tbl[i].va, tbl[i].vb, {tbl[i].ec, tbl[i].es});
    @(negedge clk);
    chk("idle_after_table", int'({busy, done}), 0);
    chk("sum_held", int'({cout, sum}), 16);

    // Exhaustive sweep.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      run_op(iv[7:4], iv[3:0], {1'b0, iv[7:4]} + {1'b0, iv[3:0]});
    end

    // start during RUN is ignored; original result arrives on time.
    start = 1'b1; a = 4'd3; b = 4'd5;
    sb_q.push_back(5'd8);
    @(negedge clk);
    a = 4'd9; b = 4'd9;
    @(negedge clk);
    start = 1'b0;
    n = 2;
    wait_done(n);
    chk("ignored_start_latency", n, W + 1);
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) cnt++;
      @(negedge clk);
    end
    chk("no_extra_op", cnt, 0);

    // Reset during the second RUN cycle aborts with no result.
    start = 1'b1; a = 4'd6; b = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outs", int'({busy, done, sum, cout}), 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    chk("no_done_after_rst", cnt, 0);

    // start held high: a result every W+1 cycles, busy low only in DONE.
    for (int i = 0; i < 3; i++) sb_q.push_back(5'd9);
    start = 1'b1; a = 4'd7; b = 4'd2;
    n = 0; cnt = 0;
    begin
      int last;
      last = 0;
      while (cnt < 3 && n < 40) begin
        @(negedge clk);
        n++;
        chk("busy_vs_done", int'(busy), int'(!done));
        if (done) begin
          cnt++;
          chk("done_spacing", n - last, W + 1);
          last = n;
          if (cnt == 3) start = 1'b0;
        end
      end
    end
    chk("held_start_results", cnt, 3);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_held", int'({busy, done}), 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
